sram_mem_ctrl: RTL and testbench
================================

Name: sram_mem_ctrl

Overview:
- Memory controller that shares the single external SRAM between two requesters: the CPU (read/write) and the VGA controller (read-only glyph/frame fetch).
- Arbitrates between them, sequences the SRAM's active-low CE/OE/WE strobes through a setup/access/recovery cycle, and returns read data with a one-cycle ack pulse.
- Sits between the CPU/VGA blocks and the SRAM pins in sys_top, and replaces the direct CPU-to-SRAM strobe wiring.

Parameters:
- DW, 16, data width (matches `DATAWIDTH).
- AW, 16, address width.
- WAIT_CYCLES, 1, extra ACCESS cycles beyond the first. Legal range 0..7.
- STARVE_LIMIT, 4, consecutive VGA grants allowed while the CPU waits. Used only with the optional feature.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read. Sampled at grant.
- cpu_addr  in  AW  CPU address. Sampled at grant.
- cpu_wdata  in  DW  CPU write data. Sampled at grant.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DW  read data, valid while cpu_ack=1 and held until the next CPU read completes.
- vga_req  in  1  VGA read request, held until vga_ack.
- vga_addr  in  AW  VGA address. Sampled at grant.
- vga_ack  out  1  one-cycle completion pulse.
- vga_rdata  out  DW  read data, valid while vga_ack=1 and held until the next VGA read completes.
- sram_ce_n, sram_oe_n, sram_we_n  out  1  SRAM strobes, active low.
- sram_lb_n, sram_ub_n  out  1  byte enables. Equal to sram_ce_n (full-word accesses only).
- sram_addr  out  AW  SRAM address.
- sram_din  out  DW  write data to the SRAM.
- sram_dout  in  DW  read data from the SRAM.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
Reset (rst=0, takes effect immediately):
- State returns to IDLE.
- All *_n strobes = 1; acks = 0; rdata, sram_addr and sram_din = 0; busy = 0; starvation counter = 0.
- Reset during a transaction aborts it with no ack. The SRAM sees the strobes deassert asynchronously.

FSM states and transitions:
- IDLE
  - If any request is pending, arbitrate and go to SETUP.
  - On grant, latch owner, addr, we and wdata into internal registers.
  - Arbitration: vga_req has priority over cpu_req.
- SETUP (1 cycle)
  - sram_ce_n=0; OE and WE stay high.
  - Latched address on sram_addr; for writes, latched data on sram_din.
  - Next state: ACCESS.
- ACCESS (WAIT_CYCLES+1 cycles, counted by a 3-bit counter)
  - CE low. OE low for a read, or WE low for a write; never both low.
  - On the last ACCESS edge, capture sram_dout into the owner's rdata register (read only).
  - Next state: DONE.
- DONE (1 cycle)
  - All strobes high. sram_addr and sram_din still held, giving hold time.
  - Owner's ack = 1.
  - Next state: IDLE (bus-turnaround cycle; no back-to-back chaining).

Timing:
- Request seen in IDLE in cycle 0 → ack in cycle 3+WAIT_CYCLES (cycle 4 at the default).
- Throughput: one access per 4+WAIT_CYCLES cycles.

Handshake rules:
- Requesters hold req and operands until ack. Changes to operands after grant are ignored.
- If a requester drops req mid-transaction, the transaction still completes and the ack still pulses.
- A requester may drop req in its ack cycle. A req still high in the following IDLE cycle counts as a new request.

Simultaneous requests:
- Both requests high in IDLE → VGA is granted. The CPU stays pending and is granted in the next IDLE cycle if VGA is not requesting.
- cpu_rdata holds its old value across VGA transactions, and vga_rdata across CPU transactions.

Optional Feature:
MEMC_STARVE_GUARD_EN
- Defined:
  - A counter increments on each VGA grant made while cpu_req=1.
  - When the count equals STARVE_LIMIT, the next arbitration grants the CPU even if vga_req=1.
  - The counter clears on any CPU grant, and whenever cpu_req=0 in IDLE.
- Undefined: strict VGA priority; no counter logic is synthesized.

Test Plan:
- Reset mid-ACCESS: assert rst=0 during an ACCESS cycle → strobes = 1 in that same cycle; no ack; FSM in IDLE after release.
- CPU write then read: write addr 0x0040, data 0xBEEF; then read 0x0040 → cpu_ack in cycle 4 each time; WE low for 2 cycles; OE never low during the write; cpu_rdata=0xBEEF.
- VGA read: SRAM model holds 0x1234 at 0x0100; vga_req with addr 0x0100 → vga_ack in cycle 4 with vga_rdata=0x1234; cpu_ack stays 0.
- Simultaneous requests: cpu_req and vga_req both high in the same cycle → VGA acked at cycle 4; CPU granted at cycle 5 and acked at cycle 9.
- WAIT_CYCLES=3 build: single CPU read → OE low for 4 cycles; ack at cycle 6; lb_n and ub_n track ce_n throughout.
- MEMC_STARVE_GUARD_EN defined, STARVE_LIMIT=4: vga_req held high continuously with cpu_req also high → exactly 4 VGA acks, then 1 CPU ack, then VGA resumes. Without the macro, no CPU ack occurs.

Source files
------------

// File: rtl/sram_mem_ctrl_if.sv
// Bus interface of sram_mem_ctrl: the CPU and VGA request channels,
// the external SRAM pins and the busy flag.
// slave  : the controller's view
// master : the requesters' view (CPU and VGA)
// mem    : the SRAM device's view
interface sram_mem_ctrl_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic          vga_ack;
  logic [DW-1:0] vga_rdata;

  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic          sram_lb_n;
  logic          sram_ub_n;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;

  logic          busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, sram_dout,
    output cpu_ack, cpu_rdata, vga_ack, vga_rdata,
           sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n,
           sram_addr, sram_din, busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr,
    input  cpu_ack, cpu_rdata, vga_ack, vga_rdata, busy
  );

  modport mem (
    input  sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_addr, sram_din,
    output sram_dout
  );
endinterface

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: shares one asynchronous SRAM between the CPU (read/write)
// and the VGA fetcher (read-only). Each access runs IDLE -> SETUP ->
// ACCESS (WAIT_CYCLES+1 cycles) -> DONE, with the owner's ack in DONE.
// VGA has strict priority over the CPU. Defining MEMC_STARVE_GUARD_EN adds
// a counter that forces a CPU grant after STARVE_LIMIT consecutive VGA
// grants made while the CPU was waiting.
module sram_mem_ctrl #(
  parameter int DW           = 16,
  parameter int AW           = 16,
  parameter int WAIT_CYCLES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic             clk,
  input logic             rst,
  sram_mem_ctrl_if.slave  bus
);

  // Reject parameter values the 3-bit wait counter or the guard cannot honour
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 7 || STARVE_LIMIT < 1) begin : g_bad_param
    $error("sram_mem_ctrl: WAIT_CYCLES must be 0..7 and STARVE_LIMIT >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE
  } state_e;

  state_e        state_q;
  logic          owner_vga_q;
  logic          we_q;
  logic [2:0]    wait_q;
  logic          ce_n_q;
  logic          oe_n_q;
  logic          we_n_q;
  logic          cpu_ack_q;
  logic          vga_ack_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] vga_rdata_q;
  logic [AW-1:0] sram_addr_q;
  logic [DW-1:0] sram_din_q;

  logic          grant_cpu_d;
  logic          grant_vga_d;
  logic          force_cpu_d;

`ifdef MEMC_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q;

  // Count VGA grants that left the CPU waiting; cleared when the CPU wins or stops asking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (grant_cpu_d || !bus.cpu_req) begin
        starve_q <= '0;
      end else if (grant_vga_d) begin
        starve_q <= starve_q + SW'(1);
      end
    end
  end

  assign force_cpu_d = bus.cpu_req && (starve_q == SW'(STARVE_LIMIT));
`else
  assign force_cpu_d = 1'b0;
`endif

  // Arbitration: VGA first unless the starvation guard forces the CPU in
  always_comb begin
    grant_cpu_d = 1'b0;
    grant_vga_d = 1'b0;
    if (force_cpu_d) begin
      grant_cpu_d = 1'b1;
    end else if (bus.vga_req) begin
      grant_vga_d = 1'b1;
    end else if (bus.cpu_req) begin
      grant_cpu_d = 1'b1;
    end
  end

  // Access sequencer with registered strobes, acks and captured read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_vga_q <= 1'b0;
      we_q        <= 1'b0;
      wait_q      <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      cpu_ack_q   <= 1'b0;
      vga_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      vga_rdata_q <= '0;
      sram_addr_q <= '0;
      sram_din_q  <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      vga_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_cpu_d || grant_vga_d) begin
            owner_vga_q <= grant_vga_d;
            we_q        <= grant_cpu_d && bus.cpu_we;
            sram_addr_q <= grant_vga_d ? bus.vga_addr : bus.cpu_addr;
            if (grant_cpu_d && bus.cpu_we) begin
              sram_din_q <= bus.cpu_wdata;
            end
            ce_n_q  <= 1'b0;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          wait_q  <= 3'(WAIT_CYCLES);
          oe_n_q  <= we_q;
          we_n_q  <= !we_q;
          state_q <= S_ACCESS;
        end
        S_ACCESS: begin
          if (wait_q == 3'd0) begin
            if (!we_q) begin
              if (owner_vga_q) begin
                vga_rdata_q <= bus.sram_dout;
              end else begin
                cpu_rdata_q <= bus.sram_dout;
              end
            end
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            vga_ack_q <= owner_vga_q;
            cpu_ack_q <= !owner_vga_q;
            state_q   <= S_DONE;
          end else begin
            wait_q <= wait_q - 3'd1;
          end
        end
        S_DONE: begin
          // Turnaround cycle: address and data stay put for hold time
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.sram_ce_n = ce_n_q;
  assign bus.sram_oe_n = oe_n_q;
  assign bus.sram_we_n = we_n_q;
  assign bus.sram_lb_n = ce_n_q;
  assign bus.sram_ub_n = ce_n_q;
  assign bus.sram_addr = sram_addr_q;
  assign bus.sram_din  = sram_din_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.vga_ack   = vga_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.vga_rdata = vga_rdata_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench for sram_mem_ctrl: table of single transactions plus
// hand-written sequences for reset mid-access, simultaneous requests,
// starvation behaviour and a WAIT_CYCLES=3 instance.
module tb_sram_mem_ctrl;
  localparam int DW = 16;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sram_mem_ctrl_if #(.DW(DW), .AW(AW)) bus ();
  sram_mem_ctrl_if #(.DW(DW), .AW(AW)) bus3 ();

  sram_mem_ctrl #(.DW(DW), .AW(AW), .WAIT_CYCLES(1), .STARVE_LIMIT(4)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  sram_mem_ctrl #(.DW(DW), .AW(AW), .WAIT_CYCLES(3), .STARVE_LIMIT(4)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  // SRAM model for the main instance
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (!bus.sram_ce_n && !bus.sram_we_n) mem[bus.sram_addr] <= bus.sram_din;
  end
  assign bus.sram_dout = (!bus.sram_ce_n && !bus.sram_oe_n) ? mem[bus.sram_addr] : 16'hDEAD;
  // Pattern SRAM for the WAIT_CYCLES=3 instance
  assign bus3.sram_dout = (!bus3.sram_ce_n && !bus3.sram_oe_n) ? (bus3.sram_addr ^ 16'h0F0F) : 16'hDEAD;

  // Strobe monitors (cumulative, sampled on the falling edge)
  int we_low = 0, oe_low = 0, both_low = 0, track_err = 0, cpu_acks = 0, vga_acks = 0;
  int oe_low3 = 0, we_low3 = 0, track_err3 = 0;
  always @(negedge clk) begin
    if (!bus.sram_we_n) we_low <= we_low + 1;
    if (!bus.sram_oe_n) oe_low <= oe_low + 1;
    if (!bus.sram_oe_n && !bus.sram_we_n) both_low <= both_low + 1;
    if (bus.sram_lb_n != bus.sram_ce_n || bus.sram_ub_n != bus.sram_ce_n) track_err <= track_err + 1;
    if (bus.cpu_ack) cpu_acks <= cpu_acks + 1;
    if (bus.vga_ack) vga_acks <= vga_acks + 1;
    if (!bus3.sram_oe_n) oe_low3 <= oe_low3 + 1;
    if (!bus3.sram_we_n) we_low3 <= we_low3 + 1;
    if (bus3.sram_lb_n != bus3.sram_ce_n || bus3.sram_ub_n != bus3.sram_ce_n) track_err3 <= track_err3 + 1;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic        is_vga;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_we_low;
    int          exp_oe_low;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int ack_cyc, other_ack;
    int w0, o0, b0, t0, c0, v0;
    int vga_cyc, cpu_cyc, nacks;
    logic [5:0] seq;
    logic [15:0] exp_cpu_rd, exp_vga_rd, got_rd;

    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0100] = 16'h1234;
    mem[16'h0041] = 16'hA5C3;

    //             vga   we    addr      wdata     exp_rdata we_low oe_low
    vecs[0] = '{1'b0, 1'b1, 16'h0040, 16'hBEEF, 16'h0000, 2, 0};
    vecs[1] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 0, 2};
    vecs[2] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 16'h1234, 0, 2};
    vecs[3] = '{1'b0, 1'b1, 16'h0100, 16'h5A5A, 16'h0000, 2, 0};
    vecs[4] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 16'h5A5A, 0, 2};
    vecs[5] = '{1'b0, 1'b0, 16'h0041, 16'h0000, 16'hA5C3, 0, 2};

    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.vga_req = 0; bus.vga_addr = 0;
    bus3.cpu_req = 0; bus3.cpu_we = 0; bus3.cpu_addr = 0; bus3.cpu_wdata = 0;
    bus3.vga_req = 0; bus3.vga_addr = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobes", {27'd0, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_lb_n, bus.sram_ub_n}, 32'h1F);
    chk("rst_acks", {30'd0, bus.cpu_ack, bus.vga_ack}, 32'h0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
    chk("rst_vga_rdata", bus.vga_rdata, 32'h0);
    chk("rst_sram_addr", bus.sram_addr, 32'h0);
    chk("rst_sram_din", bus.sram_din, 32'h0);
    chk("rst_busy", bus.busy, 32'h0);
    rst = 1'b1;

    // Table of single transactions
    exp_cpu_rd = 16'h0000;
    exp_vga_rd = 16'h0000;
    for (int k = 0; k < 6; k++) begin
      w0 = we_low; o0 = oe_low; b0 = both_low; t0 = track_err;
      @(posedge clk); #1;
      if (vecs[k].is_vga) begin
        bus.vga_req = 1; bus.vga_addr = vecs[k].addr;
      end else begin
        bus.cpu_req = 1; bus.cpu_we = vecs[k].we;
        bus.cpu_addr = vecs[k].addr; bus.cpu_wdata = vecs[k].wdata;
      end
      ack_cyc = -1; other_ack = 0;
      for (int n = 1; n <= 20 && ack_cyc < 0; n++) begin
        @(posedge clk); #1;
        // Operand changes after grant must be ignored
        if (n == 1) begin
          bus.cpu_addr = 16'hFFFF; bus.cpu_wdata = 16'h0BAD; bus.vga_addr = 16'hFFFF;
        end
        if (vecs[k].is_vga ? bus.vga_ack : bus.cpu_ack) begin
          ack_cyc = n;
          bus.vga_req = 0; bus.cpu_req = 0;
        end
        if (vecs[k].is_vga ? bus.cpu_ack : bus.vga_ack) other_ack++;
      end
      bus.vga_req = 0; bus.cpu_req = 0;
      if (!vecs[k].we) begin
        if (vecs[k].is_vga) exp_vga_rd = vecs[k].exp_rdata;
        else exp_cpu_rd = vecs[k].exp_rdata;
      end
      chk($sformatf("v%0d_ack_cycle", k), ack_cyc, 4);
      chk($sformatf("v%0d_other_ack", k), other_ack, 0);
      chk($sformatf("v%0d_cpu_rdata", k), bus.cpu_rdata, {16'd0, exp_cpu_rd});
      chk($sformatf("v%0d_vga_rdata", k), bus.vga_rdata, {16'd0, exp_vga_rd});
      @(negedge clk);
      chk($sformatf("v%0d_we_low", k), we_low - w0, vecs[k].exp_we_low);
      chk($sformatf("v%0d_oe_low", k), oe_low - o0, vecs[k].exp_oe_low);
      chk($sformatf("v%0d_both_low", k), both_low - b0, 0);
      chk($sformatf("v%0d_lb_ub_track", k), track_err - t0, 0);
    end
    chk("mem_0040", mem[16'h0040], 32'hBEEF);

    // Reset in the middle of ACCESS
    @(posedge clk); #1;
    c0 = cpu_acks;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0040;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_in_access", {30'd0, bus.sram_ce_n, bus.sram_oe_n}, 32'h0);
    #1 rst = 1'b0;
    #1;
    chk("midrst_strobes", {27'd0, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_lb_n, bus.sram_ub_n}, 32'h1F);
    chk("midrst_busy", bus.busy, 32'h0);
    chk("midrst_cpu_rdata", bus.cpu_rdata, 32'h0);
    bus.cpu_req = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_idle_after", bus.busy, 32'h0);
    chk("midrst_no_ack", cpu_acks - c0, 0);

    // Simultaneous requests: VGA first, CPU granted in the next IDLE cycle
    @(posedge clk); #1;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0040;
    bus.vga_req = 1; bus.vga_addr = 16'h0100;
    vga_cyc = -1; cpu_cyc = -1;
    for (int n = 1; n <= 20 && cpu_cyc < 0; n++) begin
      @(posedge clk); #1;
      if (bus.vga_ack) begin vga_cyc = n; bus.vga_req = 0; chk("sim_vga_rdata", bus.vga_rdata, 32'h5A5A); end
      if (bus.cpu_ack) begin cpu_cyc = n; bus.cpu_req = 0; chk("sim_cpu_rdata", bus.cpu_rdata, 32'hBEEF); end
    end
    bus.cpu_req = 0; bus.vga_req = 0;
    chk("sim_vga_ack_cycle", vga_cyc, 4);
    chk("sim_cpu_ack_cycle", cpu_cyc, 9);

    // Both requests held high: record the owner of the first six acks
    @(posedge clk); #1;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0041;
    bus.vga_req = 1; bus.vga_addr = 16'h0100;
    seq = '0; nacks = 0;
    for (int n = 1; n <= 80 && nacks < 6; n++) begin
      @(posedge clk); #1;
      if (bus.cpu_ack) begin seq[nacks] = 1'b1; nacks++; end
      else if (bus.vga_ack) nacks++;
    end
    bus.cpu_req = 0; bus.vga_req = 0;
    chk("starve_ack_count", nacks, 6);
`ifdef MEMC_STARVE_GUARD_EN
    chk("starve_order", {26'd0, seq}, 32'b010000);
`else
    chk("starve_order", {26'd0, seq}, 32'b000000);
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("starve_drained", bus.busy, 32'h0);

    // WAIT_CYCLES=3 instance: single CPU read
    o0 = oe_low3; w0 = we_low3; t0 = track_err3;
    @(posedge clk); #1;
    bus3.cpu_req = 1; bus3.cpu_we = 0; bus3.cpu_addr = 16'h0077;
    ack_cyc = -1; got_rd = 16'h0;
    for (int n = 1; n <= 20 && ack_cyc < 0; n++) begin
      @(posedge clk); #1;
      if (bus3.cpu_ack) begin ack_cyc = n; got_rd = bus3.cpu_rdata; bus3.cpu_req = 0; end
    end
    bus3.cpu_req = 0;
    @(negedge clk);
    chk("w3_ack_cycle", ack_cyc, 6);
    chk("w3_cpu_rdata", got_rd, 32'h0F78);
    chk("w3_oe_low", oe_low3 - o0, 4);
    chk("w3_we_low", we_low3 - w0, 0);
    chk("w3_lb_ub_track", track_err3 - t0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
